// File: rtl/truth_table_sweeper_pkg.sv
// ============================================================================
// Module   : truth_table_sweeper_pkg
// Brief    : Shared state encoding and default sizing for the truth-table sweeper.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package truth_table_sweeper_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_DRIVE  = 2'd1;
    localparam logic [1:0] ST_SAMPLE = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    localparam int DEFAULT_N_IN          = 4;
    localparam int DEFAULT_SETTLE_CYCLES = 1;
    localparam int TABLE_W               = 2 ** DEFAULT_N_IN;

endpackage

`default_nettype wire

// File: rtl/truth_table_sweeper_sweep_counter.sv
// ============================================================================
// Module   : sweep_counter
// Brief    : Vector index counter with clear, increment and terminal-count flag.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sweep_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] idx,
    output logic         last
);

    localparam logic [W-1:0] c_one  = {{(W-1){1'b0}}, 1'b1};
    localparam logic [W-1:0] c_term = {W{1'b1}};

    logic [W-1:0] r_idx;

    // Clear has priority so the index can never wrap past the last vector.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx <= '0;
        end else if (clr) begin
            r_idx <= '0;
        end else if (inc) begin
            r_idx <= r_idx + c_one;
        end
    end

    assign idx  = r_idx;
    assign last = (r_idx == c_term);

endmodule

`default_nettype wire

// File: rtl/truth_table_sweeper.sv
// ============================================================================
// Module   : truth_table_sweeper
// Brief    : Sweeps every input vector of a function block, captures its truth
//            table and compares it against a golden table.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module truth_table_sweeper
    import truth_table_sweeper_pkg::*;
#(
    parameter int N_IN          = DEFAULT_N_IN,
    parameter int SETTLE_CYCLES = DEFAULT_SETTLE_CYCLES
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [2**N_IN-1:0]   expected,
    input  logic                 f_in,
    output logic [N_IN-1:0]      vec,
    output logic                 en,
    output logic                 busy,
    output logic                 done,
    output logic [2**N_IN-1:0]   table_out,
    output logic                 pass,
    output logic [N_IN:0]        mismatch_cnt,
    output logic [N_IN-1:0]      first_mismatch
);

    localparam int         c_table_w     = 2 ** N_IN;
    localparam logic [3:0] c_settle_last = 4'(SETTLE_CYCLES - 1);
    localparam logic [3:0] c_settle_one  = 4'd1;

    logic [1:0]           r_state;
    logic [1:0]           w_state_next;
    logic [3:0]           r_settle;
    logic [c_table_w-1:0] r_exp;
    logic [c_table_w-1:0] r_table;
    logic                 r_active;
    logic                 r_done;
    logic                 r_pass;
    logic [N_IN:0]        r_cnt;
    logic [N_IN-1:0]      r_first;

    logic                 w_accept;
    logic                 w_sample;
    logic                 w_settle_hit;
    logic                 w_miss;
    logic [N_IN:0]        w_cnt_next;
    logic [N_IN-1:0]      w_idx;
    logic                 w_last;
    logic                 w_idx_clr;
    logic                 w_idx_inc;

    assign w_accept     = (r_state == ST_IDLE) && start;
    assign w_sample     = (r_state == ST_SAMPLE);
    assign w_settle_hit = (r_settle == c_settle_last);
    assign w_miss       = w_sample && (f_in != r_exp[w_idx]);
    assign w_cnt_next   = r_cnt + {{N_IN{1'b0}}, w_miss};

    // Clearing the index after the last sample keeps it at zero through
    // DONE and IDLE, so the counter output can drive vec directly.
    assign w_idx_clr = w_accept || (w_sample && w_last);
    assign w_idx_inc = w_sample && !w_last;

    sweep_counter #(
        .W    (N_IN)
    ) u_counter (
        .clk  (clk),
        .rst  (rst),
        .clr  (w_idx_clr),
        .inc  (w_idx_inc),
        .idx  (w_idx),
        .last (w_last)
    );

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:   if (start) w_state_next = ST_DRIVE;
            ST_DRIVE:  if (w_settle_hit) w_state_next = ST_SAMPLE;
            ST_SAMPLE: w_state_next = w_last ? ST_DONE : ST_DRIVE;
            ST_DONE:   w_state_next = ST_IDLE;
            default:   w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_settle <= '0;
            r_exp    <= '0;
            r_table  <= '0;
            r_active <= 1'b0;
            r_done   <= 1'b0;
            r_pass   <= 1'b0;
            r_cnt    <= '0;
            r_first  <= '0;
        end else begin
            r_state  <= w_state_next;
            r_active <= (w_state_next == ST_DRIVE) || (w_state_next == ST_SAMPLE);
            r_done   <= (w_state_next == ST_DONE);

            if (r_state == ST_DRIVE) begin
                r_settle <= w_settle_hit ? 4'd0 : (r_settle + c_settle_one);
            end

            if (w_accept) begin
                r_exp    <= expected;
                r_table  <= '0;
                r_cnt    <= '0;
                r_first  <= '0;
                r_pass   <= 1'b0;
                r_settle <= '0;
            end

            if (w_sample) begin
                r_table[w_idx] <= f_in;
                r_cnt          <= w_cnt_next;
                if (w_miss && (r_cnt == '0)) begin
                    r_first <= w_idx;
                end
                // Pass must include the verdict of the final vector.
                if (w_last) begin
                    r_pass <= (w_cnt_next == '0);
                end
            end
        end
    end

    assign vec            = w_idx;
    assign en             = r_active;
    assign busy           = r_active;
    assign done           = r_done;
    assign table_out      = r_table;
    assign pass           = r_pass;
    assign mismatch_cnt   = r_cnt;
    assign first_mismatch = r_first;

endmodule

`default_nettype wire

// File: tb/tb_truth_table_sweeper.sv
// ============================================================================
// Module   : tb_truth_table_sweeper
// Brief    : Self-checking bench for truth_table_sweeper with a behavioural
//            function block and a result scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_truth_table_sweeper;

    typedef struct packed {
        logic [15:0] tbl;
        logic [4:0]  cnt;
        logic [3:0]  first;
        logic        pass;
    } res_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start1, start3;
    logic [15:0] expected;
    int          mode;

    logic        f1, f3;
    logic [3:0]  vec1, vec3;
    logic        en1, en3, busy1, busy3, done1, done3;
    logic [15:0] table1, table3;
    logic        pass1, pass3;
    logic [4:0]  cnt1, cnt3;
    logic [3:0]  first1, first3;

    int   total = 0;
    int   bad   = 0;
    res_t sb[$];

    always #5 clk = ~clk;

    // Function block under test: 0 = a&b&c&d&e, 1 = a^b^c^d, other = constant 0.
    function automatic logic fmodel(int m, logic [3:0] v, logic e);
        case (m)
            0:       return (&v) & e;
            1:       return ^v;
            default: return 1'b0;
        endcase
    endfunction

    assign f1 = fmodel(mode, vec1, en1);
    assign f3 = fmodel(mode, vec3, en3);

    truth_table_sweeper #(.N_IN(4), .SETTLE_CYCLES(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .expected(expected), .f_in(f1),
        .vec(vec1), .en(en1), .busy(busy1), .done(done1), .table_out(table1),
        .pass(pass1), .mismatch_cnt(cnt1), .first_mismatch(first1)
    );

    truth_table_sweeper #(.N_IN(4), .SETTLE_CYCLES(3)) u_dut3 (
        .clk(clk), .rst(rst), .start(start3), .expected(expected), .f_in(f3),
        .vec(vec3), .en(en3), .busy(busy3), .done(done3), .table_out(table3),
        .pass(pass3), .mismatch_cnt(cnt3), .first_mismatch(first3)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_expected(input int m, input logic [15:0] ex);
        res_t        r;
        logic [15:0] diff;
        r.tbl = '0;
        for (int i = 0; i < 16; i++) r.tbl[i] = fmodel(m, 4'(i), 1'b1);
        diff    = r.tbl ^ ex;
        r.cnt   = 5'($countones(diff));
        r.first = 4'd0;
        for (int i = 15; i >= 0; i--) if (diff[i]) r.first = 4'(i);
        r.pass  = (diff == 16'h0000);
        sb.push_back(r);
    endtask

    task automatic sweep(input int sel, input int m, input logic [15:0] ex,
                         input int settle, input bit poke);
        int          per;
        int          blen;
        int          ndone;
        int          donek;
        logic [6:0]  obs;
        logic [6:0]  want;
        res_t        r;
        per   = settle + 1;
        blen  = 16 * per;
        ndone = 0;
        donek = 0;
        mode  = m;
        expected = ex;
        push_expected(m, ex);
        @(negedge clk);
        if (sel == 1) start1 = 1'b1; else start3 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start1 = 1'b0;
        start3 = 1'b0;
        expected = ~ex;
        for (int k = 1; k <= blen + 3; k++) begin
            if (sel == 1) obs = {done1, busy1, en1, vec1};
            else          obs = {done3, busy3, en3, vec3};
            want = {(k == blen + 1), (k <= blen), (k <= blen),
                    (k <= blen) ? 4'((k - 1) / per) : 4'd0};
            check($sformatf("cycle%0d done/busy/en/vec", k), 32'(obs), 32'(want));
            if (obs[6]) begin
                ndone++;
                donek = k;
            end
            if (poke && (k == 5 || k == 20 || k == blen + 1)) begin
                if (sel == 1) start1 = 1'b1; else start3 = 1'b1;
            end
            @(negedge clk);
            start1 = 1'b0;
            start3 = 1'b0;
        end
        check("done_count", 32'(ndone), 32'd1);
        check("done_cycle", 32'(donek), 32'(blen + 1));
        if (sb.size() == 0) begin
            check("scoreboard_empty", 32'd0, 32'd1);
        end else begin
            r = sb.pop_front();
            if (sel == 1) begin
                check("table_out", 32'(table1), 32'(r.tbl));
                check("mismatch_cnt", 32'(cnt1), 32'(r.cnt));
                check("first_mismatch", 32'(first1), 32'(r.first));
                check("pass", 32'(pass1), 32'(r.pass));
            end else begin
                check("table_out", 32'(table3), 32'(r.tbl));
                check("mismatch_cnt", 32'(cnt3), 32'(r.cnt));
                check("first_mismatch", 32'(first3), 32'(r.first));
                check("pass", 32'(pass3), 32'(r.pass));
            end
        end
    endtask

    initial begin
        rst      = 1'b1;
        start1   = 1'b1;
        start3   = 1'b0;
        expected = 16'h8000;
        mode     = 0;
        repeat (2) @(negedge clk);
        check("reset_outputs_dut1",
              32'({vec1, en1, busy1, done1, pass1, cnt1, first1, table1 != 16'h0}), 32'd0);
        check("reset_outputs_dut3",
              32'({vec3, en3, busy3, done3, pass3, cnt3, first3, table3 != 16'h0}), 32'd0);
        start1 = 1'b0;
        rst    = 1'b0;
        @(negedge clk);
        check("start_with_rst_ignored", 32'(busy1), 32'd0);

        // AND model with matching golden table.
        sweep(1, 0, 16'h8000, 1, 1'b0);
        // AND model, golden table differs at vector 0.
        sweep(1, 0, 16'h8001, 1, 1'b0);
        // Parity model with longer settle time.
        sweep(3, 1, 16'h6996, 3, 1'b0);
        // Extra starts mid-sweep and in DONE must be ignored.
        sweep(1, 0, 16'h8000, 1, 1'b1);

        // Reset in cycle 10 of a parity sweep.
        mode     = 1;
        expected = 16'h6996;
        @(negedge clk);
        start1 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start1 = 1'b0;
        repeat (9) @(negedge clk);
        check("midsweep_busy", 32'(busy1), 32'd1);
        check("midsweep_partial_table", 32'(table1), 32'h0006);
        rst = 1'b1;
        #1;
        check("async_reset_outputs",
              32'({vec1, en1, busy1, done1, pass1, cnt1, first1, table1 != 16'h0}), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("post_reset_idle", 32'({done1, busy1, en1}), 32'd0);
        end
        sweep(1, 1, 16'h6996, 1, 1'b0);

        // Constant-zero model against an all-ones table.
        sweep(1, 2, 16'hFFFF, 1, 1'b0);
        check("all_miss_cnt", 32'(cnt1), 32'd16);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/truth_table_sweeper.md
Name: truth_table_sweeper

Overview:
- Sequencer that exhaustively exercises a 4-input combinational function block with an enable input (a,b,c,d,e -> f).
- Steps the input vector 0000..1111 with enable held high and waits a programmable settle time per vector.
- Samples f into a 2^N-bit truth-table register and compares the result against an expected table.
- Sits between a start/result interface (lab board buttons/LEDs or a bench) and the function block under test.

Parameters:
- N_IN, 4, number of data inputs swept; the table is 2**N_IN bits wide.
- SETTLE_CYCLES, 1, clock cycles each vector is held before sampling; legal range 1..15.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle request to begin a sweep; honoured only in IDLE.
- expected  input  2**N_IN  golden truth table, bit i = expected f for vector i; sampled on the accepted start.
- f_in  input  1  output f of the function block.
- vec  output  N_IN  drives the function inputs, vec[N_IN-1]=a ... vec[0]=d.
- en  output  1  drives the function enable input e.
- busy  output  1  high from the cycle after start acceptance until DONE is entered.
- done  output  1  one-cycle pulse at sweep completion.
- table_out  output  2**N_IN  captured truth table.
- pass  output  1  table_out == captured expected; valid from done, held until the next accepted start.
- mismatch_cnt  output  N_IN+1  number of differing bits.
- first_mismatch  output  N_IN  lowest vector index that differed; 0 if none.

Behaviour:
- Reset (asynchronous, immediate) clears all outputs and internal state to 0; state=IDLE. Reset mid-sweep aborts with no done pulse, and the partial table is discarded.
- States: IDLE, DRIVE, SAMPLE, DONE.
- IDLE:
  - en=0, vec=0.
  - start=1 -> latch expected, clear table_out, mismatch_cnt, first_mismatch, pass and the idx/settle counters.
  - Go to DRIVE.
- DRIVE:
  - vec=idx, en=1.
  - settle counter increments each cycle.
  - When it reaches SETTLE_CYCLES-1 -> SAMPLE; counter cleared.
- SAMPLE:
  - vec=idx, en=1.
  - At the closing edge: table_out[idx]<=f_in.
  - If f_in != exp[idx], mismatch_cnt increments; if it was 0, first_mismatch<=idx.
  - If idx==2**N_IN-1 -> DONE, else idx+1 -> DRIVE.
- DONE: one cycle; done=1, en=0, vec=0, pass=(mismatch_cnt==0) registered on entry; -> IDLE.
- Timing:
  - Each vector occupies SETTLE_CYCLES+1 cycles.
  - busy spans 2**N_IN*(SETTLE_CYCLES+1) cycles; done is asserted in the following cycle.
  - N_IN=4, S=1: 32 busy cycles, done in cycle 33 after the accept edge.
- start while busy or in DONE is ignored and not queued.
- start in the same cycle as rst: rst wins.
- idx is N_IN bits and never wraps within a sweep; the last index is detected explicitly.
- mismatch_cnt is N_IN+1 bits, so it holds 2**N_IN without overflow.
- f_in changing during DRIVE has no effect; only the SAMPLE-cycle value is captured.
- Outputs are registered. vec/en are registered and change only on clock edges, so they are glitch-free.

Decomposition:
- Shared package holds:
  - state encoding constants ST_IDLE=2'd0, ST_DRIVE=2'd1, ST_SAMPLE=2'd2, ST_DONE=2'd3;
  - default N_IN and SETTLE_CYCLES localparams;
  - TABLE_W = 2**N_IN.
- One sub-module, sweep_counter:
  - N_IN-bit index counter with clear, increment and terminal-count flag;
  - asynchronous active-high reset.
- The FSM, capture and compare logic stay in truth_table_sweeper.

Test Plan:
- Function model f=a&b&c&d&e, expected=16'h8000, S=1, start pulse:
  - vec steps 0..15 with en=1;
  - done at cycle 33 after accept;
  - table_out=16'h8000, pass=1, mismatch_cnt=0.
- Same model, expected=16'h8001:
  - pass=0, mismatch_cnt=1, first_mismatch=0;
  - table_out=16'h8000.
- Model f=a^b^c^d, expected=16'h6996, SETTLE_CYCLES=3:
  - each vector held 4 cycles;
  - done at cycle 65;
  - pass=1.
- Re-assert start at cycles 5 and 20 of a sweep:
  - no restart;
  - done occurs exactly once at cycle 33.
- Assert rst at cycle 10 of a sweep:
  - all outputs 0 within the same cycle, state IDLE, no done.
  - A new start then completes a full sweep with correct table_out.
- Model f=0, expected=16'hFFFF:
  - mismatch_cnt=16 (5'b10000), first_mismatch=0, pass=0.
